// File: rtl/serial_output.sv
// UART transmitter: 8N1 framing, one stream word per frame.
// Baud timing derived from CLOCK_FREQUENCY / BAUD_RATE.
module serial_output #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_tx,
    input  logic        input_tx_stb,
    output logic        input_tx_ack,
    output logic        tx
);

    localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             ack_q, ack_d;

    logic             bit_end;
    logic [2:0]       idx_nxt;
    logic             unused_upper;

    assign unused_upper = ^input_tx[31:8];
    assign bit_end      = (cnt_q == CNT_MAX);
    assign idx_nxt      = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;
        ack_d   = ack_q;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                ack_d = 1'b1;
                cnt_d = '0;
                idx_d = 3'd0;
                if (input_tx_stb && ack_q) begin
                    data_d  = input_tx[7:0];
                    state_d = START;
                    tx_d    = 1'b0;
                    ack_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data_q[idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ack_d   = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset wins over a simultaneous transfer: no word is taken on a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
            ack_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
        end
    end

    assign tx           = tx_q;
    assign input_tx_ack = ack_q;

endmodule

// File: tb/tb_serial_output.sv
// Scoreboard bench for serial_output: default-rate and slow-rate instances.
// Stimulus queues expected frames; per-instance monitors decode tx line.
module tb_serial_output;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        stb0, stb1;
    logic        ack0, ack1;
    logic        tx0, tx1;
    logic [31:0] in0, in1;

    always #5 clk = ~clk;

    serial_output u0 (
        .clk          (clk),
        .rst          (rst0),
        .input_tx     (in0),
        .input_tx_stb (stb0),
        .input_tx_ack (ack0),
        .tx           (tx0)
    );

    serial_output #(
        .CLOCK_FREQUENCY (50000000),
        .BAUD_RATE       (9600)
    ) u1 (
        .clk          (clk),
        .rst          (rst1),
        .input_tx     (in1),
        .input_tx_stb (stb1),
        .input_tx_ack (ack1),
        .tx           (tx1)
    );

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic get_tx(input int id);
        return (id == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_ack(input int id);
        return (id == 0) ? ack0 : ack1;
    endfunction

    function automatic logic get_rst(input int id);
        return (id == 0) ? rst0 : rst1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input logic [7:0] b, input int start);
        exp_t e;
        e.b     = b;
        e.start = start;
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Called at a negedge with stb already driven; returns the transfer edge.
    task automatic accept(input int id, input logic [7:0] b, output int k);
        int n = 0;
        while (!get_ack(id) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60000) chk("accept_timeout", 0, 1);
        k = cyc + 1;
        push(id, b, k);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int id, output int len);
        len = 0;
        while (!get_ack(id) && len < 60000) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic monitor(input int id, input int cpb);
        exp_t e;
        logic v;
        logic ok;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (!get_rst(id) && get_tx(id) == 1'b0) begin
                if ((id == 0 ? q0.size() : q1.size()) == 0) begin
                    chk($sformatf("unexpected_frame_%0d", id), 0, 1);
                    e.b     = 8'h00;
                    e.start = cyc;
                end else if (id == 0) begin
                    e = q0.pop_front();
                end else begin
                    e = q1.pop_front();
                end
                chk($sformatf("start_cycle_%0d_%02h", id, e.b), cyc, e.start);
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    if (b == 0) v = 1'b0;
                    else if (b == 9) v = 1'b1;
                    else v = e.b[b-1];
                    ok = 1'b1;
                    for (int j = 0; j < cpb; j++) begin
                        if (b != 0 || j != 0) @(negedge clk);
                        if (get_rst(id)) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (get_tx(id) !== v) ok = 1'b0;
                    end
                    if (aborted) break;
                    chk($sformatf("bit%0d_%0d_%02h", b, id, e.b), int'(ok), 1);
                end
            end
        end
    endtask

    initial begin
        int k;
        int len;
        int bad;
        rst0 = 1'b1;
        rst1 = 1'b1;
        stb0 = 1'b0;
        stb1 = 1'b0;
        in0  = 32'd0;
        in1  = 32'd0;
        fork
            monitor(0, 868);
            monitor(1, 5208);
        join_none
        repeat (3) @(negedge clk);
        chk("rst_tx0", int'(tx0), 1);
        chk("rst_ack0", int'(ack0), 1);
        chk("rst_tx1", int'(tx1), 1);
        chk("rst_ack1", int'(ack1), 1);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);

        fork
            begin
                bad = 0;
                for (int i = 0; i < 10000; i++) begin
                    if (tx0 !== 1'b1 || ack0 !== 1'b1) bad++;
                    @(negedge clk);
                end
                chk("idle_quiet", bad, 0);

                in0  = 32'h00000055;
                stb0 = 1'b1;
                accept(0, 8'h55, k);
                stb0 = 1'b0;
                in0  = 32'hFFFFFFFF;
                wait_idle(0, len);
                chk("ack_low_55", len, 8680);

                in0  = 32'hFFFFFF41;
                stb0 = 1'b1;
                accept(0, 8'h41, k);
                for (int i = 0; i < 100; i++) begin
                    stb0 = i[0];
                    in0  = 32'h000000FF ^ i;
                    @(negedge clk);
                end
                stb0 = 1'b0;
                wait_idle(0, len);
                chk("ack_low_41", len, 8580);

                in0  = 32'h00000048;
                stb0 = 1'b1;
                accept(0, 8'h48, k);
                in0 = 32'h00000069;
                push(0, 8'h69, k + 8681);
                wait_idle(0, len);
                chk("b2b_ack_low1", len, 8680);
                @(negedge clk);
                chk("b2b_ack_one_cycle", int'(ack0), 0);
                stb0 = 1'b0;
                wait_idle(0, len);
                chk("b2b_ack_low2", len, 8680);

                in0  = 32'h000000C3;
                stb0 = 1'b1;
                accept(0, 8'hC3, k);
                stb0 = 1'b0;
                while (cyc < k + 2999) @(negedge clk);
                rst0 = 1'b1;
                @(negedge clk);
                chk("abort_tx", int'(tx0), 1);
                chk("abort_ack", int'(ack0), 1);
                @(negedge clk);
                rst0 = 1'b0;
                in0  = 32'h0000000A;
                stb0 = 1'b1;
                accept(0, 8'h0A, k);
                stb0 = 1'b0;
                wait_idle(0, len);
                chk("ack_low_0a", len, 8680);
            end
            begin
                in1  = 32'h123456A5;
                stb1 = 1'b1;
                accept(1, 8'hA5, k);
                stb1 = 1'b0;
                wait_idle(1, len);
                chk("ack_low_slow", len, 52080);
            end
        join

        repeat (5) @(negedge clk);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
